// File: rtl/schedule_1st_pkg.sv
// Shared opcode constants, instruction bundle and register-usage decode
// for the first scheduling stage.
package schedule_1st_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_JALR = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } instr_t;

    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_R, OP_S, OP_B,
            OP_I_JALR, OP_LOAD, OP_I_ALU, OP_SYSTEM: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_S, OP_B: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_R, OP_I_JALR, OP_LOAD, OP_I_ALU, OP_SYSTEM,
            OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/schedule_1st_scoreboard.sv
// 32-entry busy scoreboard: one set port (issue), one clear port (writeback),
// two read ports. Macro SCHEDULE_1ST_WB_BYPASS_EN lets a same-cycle WB hide busy.
module schedule_1st_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       set_en,
    input  logic [4:0] set_rd,
    input  logic       clr_en,
    input  logic [4:0] clr_rd,
    input  logic [4:0] rd_a,
    input  logic [4:0] rd_b,
    output logic       busy_a,
    output logic       busy_b
);

    logic [31:0] busy;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] busy_next;

    // set is applied after clear so a same-register set/clear leaves it busy
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_rd] = 1'b1;
        if (clr_en) clr_mask[clr_rd] = 1'b1;
        busy_next    = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) busy <= '0;
        else              busy <= busy_next;
    end

`ifdef SCHEDULE_1ST_WB_BYPASS_EN
    always_comb begin
        busy_a = busy[rd_a] & ~(clr_en && (clr_rd == rd_a));
        busy_b = busy[rd_b] & ~(clr_en && (clr_rd == rd_b));
    end
`else
    always_comb begin
        busy_a = busy[rd_a];
        busy_b = busy[rd_b];
    end
`endif

endmodule

// File: rtl/schedule_1st.sv
// Issue scheduler: holds one decoded instr, issues it when sources are free
// and execute has room, else raises STALL. Option: SCHEDULE_1ST_WB_BYPASS_EN.
// Ports: CLK/RST/FLUSH, DECODE_2ND_* in, STALL out, EXEC_READY, WB_VALID/WB_RD,
// SCHEDULE_1ST_* registered issue outputs.
module schedule_1st
    import schedule_1st_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        DECODE_2ND_VALID,
    input  logic [31:0] DECODE_2ND_PC,
    input  logic [6:0]  DECODE_2ND_OPCODE,
    input  logic [4:0]  DECODE_2ND_RD,
    input  logic [4:0]  DECODE_2ND_RS1,
    input  logic [4:0]  DECODE_2ND_RS2,
    input  logic [2:0]  DECODE_2ND_FUNCT3,
    input  logic [6:0]  DECODE_2ND_FUNCT7,
    input  logic [31:0] DECODE_2ND_IMM,
    output logic        STALL,
    input  logic        EXEC_READY,
    input  logic        WB_VALID,
    input  logic [4:0]  WB_RD,
    output logic        SCHEDULE_1ST_VALID,
    output logic [31:0] SCHEDULE_1ST_PC,
    output logic [6:0]  SCHEDULE_1ST_OPCODE,
    output logic [4:0]  SCHEDULE_1ST_RD,
    output logic [4:0]  SCHEDULE_1ST_RS1,
    output logic [4:0]  SCHEDULE_1ST_RS2,
    output logic [2:0]  SCHEDULE_1ST_FUNCT3,
    output logic [6:0]  SCHEDULE_1ST_FUNCT7,
    output logic [31:0] SCHEDULE_1ST_IMM
);

    instr_t dec;
    instr_t hold;
    instr_t out_q;
    logic   hold_valid;
    logic   out_valid;
    logic   busy_a;
    logic   busy_b;
    logic   hazard;
    logic   out_free;
    logic   issue;
    logic   set_en;

    always_comb begin
        dec.pc     = DECODE_2ND_PC;
        dec.opcode = DECODE_2ND_OPCODE;
        dec.rd     = DECODE_2ND_RD;
        dec.rs1    = DECODE_2ND_RS1;
        dec.rs2    = DECODE_2ND_RS2;
        dec.funct3 = DECODE_2ND_FUNCT3;
        dec.funct7 = DECODE_2ND_FUNCT7;
        dec.imm    = DECODE_2ND_IMM;
    end

    schedule_1st_scoreboard u_sb (
        .clk    (CLK),
        .rst    (RST),
        .flush  (FLUSH),
        .set_en (set_en),
        .set_rd (hold.rd),
        .clr_en (WB_VALID),
        .clr_rd (WB_RD),
        .rd_a   (hold.rs1),
        .rd_b   (hold.rs2),
        .busy_a (busy_a),
        .busy_b (busy_b)
    );

    // x0 reads as free because the scoreboard never sets bit 0
    always_comb begin
        hazard   = (uses_rs1(hold.opcode) & busy_a)
                 | (uses_rs2(hold.opcode) & busy_b);
        out_free = ~out_valid | EXEC_READY;
        issue    = ~RST & ~FLUSH & hold_valid & ~hazard & out_free;
        STALL    = ~RST & ~FLUSH & hold_valid & ~issue;
        set_en   = issue & writes_rd(hold.opcode) & (hold.rd != 5'd0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_valid <= 1'b0;
            hold       <= '0;
            out_valid  <= 1'b0;
            out_q      <= '0;
        end else if (FLUSH) begin
            hold_valid <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            if (!STALL) begin
                hold       <= dec;
                hold_valid <= DECODE_2ND_VALID;
            end
            if (issue) begin
                out_q     <= hold;
                out_valid <= 1'b1;
            end else if (EXEC_READY) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        SCHEDULE_1ST_VALID  = out_valid;
        SCHEDULE_1ST_PC     = out_q.pc;
        SCHEDULE_1ST_OPCODE = out_q.opcode;
        SCHEDULE_1ST_RD     = out_q.rd;
        SCHEDULE_1ST_RS1    = out_q.rs1;
        SCHEDULE_1ST_RS2    = out_q.rs2;
        SCHEDULE_1ST_FUNCT3 = out_q.funct3;
        SCHEDULE_1ST_FUNCT7 = out_q.funct7;
        SCHEDULE_1ST_IMM    = out_q.imm;
    end

endmodule

// File: tb/tb_schedule_1st.sv
// Directed, table-driven bench for schedule_1st.
// Expected values follow SCHEDULE_1ST_WB_BYPASS_EN when it is defined.
module tb_schedule_1st;
    import schedule_1st_pkg::*;

`ifdef SCHEDULE_1ST_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FLUSH = 1'b0;
    logic        DECODE_2ND_VALID = 1'b0;
    logic [31:0] DECODE_2ND_PC = '0;
    logic [6:0]  DECODE_2ND_OPCODE = '0;
    logic [4:0]  DECODE_2ND_RD = '0;
    logic [4:0]  DECODE_2ND_RS1 = '0;
    logic [4:0]  DECODE_2ND_RS2 = '0;
    logic [2:0]  DECODE_2ND_FUNCT3 = '0;
    logic [6:0]  DECODE_2ND_FUNCT7 = '0;
    logic [31:0] DECODE_2ND_IMM = '0;
    logic        STALL;
    logic        EXEC_READY = 1'b1;
    logic        WB_VALID = 1'b0;
    logic [4:0]  WB_RD = '0;
    logic        SCHEDULE_1ST_VALID;
    logic [31:0] SCHEDULE_1ST_PC;
    logic [6:0]  SCHEDULE_1ST_OPCODE;
    logic [4:0]  SCHEDULE_1ST_RD;
    logic [4:0]  SCHEDULE_1ST_RS1;
    logic [4:0]  SCHEDULE_1ST_RS2;
    logic [2:0]  SCHEDULE_1ST_FUNCT3;
    logic [6:0]  SCHEDULE_1ST_FUNCT7;
    logic [31:0] SCHEDULE_1ST_IMM;

    always #5 CLK = ~CLK;

    schedule_1st dut (
        .CLK                (CLK),
        .RST                (RST),
        .FLUSH              (FLUSH),
        .DECODE_2ND_VALID   (DECODE_2ND_VALID),
        .DECODE_2ND_PC      (DECODE_2ND_PC),
        .DECODE_2ND_OPCODE  (DECODE_2ND_OPCODE),
        .DECODE_2ND_RD      (DECODE_2ND_RD),
        .DECODE_2ND_RS1     (DECODE_2ND_RS1),
        .DECODE_2ND_RS2     (DECODE_2ND_RS2),
        .DECODE_2ND_FUNCT3  (DECODE_2ND_FUNCT3),
        .DECODE_2ND_FUNCT7  (DECODE_2ND_FUNCT7),
        .DECODE_2ND_IMM     (DECODE_2ND_IMM),
        .STALL              (STALL),
        .EXEC_READY         (EXEC_READY),
        .WB_VALID           (WB_VALID),
        .WB_RD              (WB_RD),
        .SCHEDULE_1ST_VALID (SCHEDULE_1ST_VALID),
        .SCHEDULE_1ST_PC    (SCHEDULE_1ST_PC),
        .SCHEDULE_1ST_OPCODE(SCHEDULE_1ST_OPCODE),
        .SCHEDULE_1ST_RD    (SCHEDULE_1ST_RD),
        .SCHEDULE_1ST_RS1   (SCHEDULE_1ST_RS1),
        .SCHEDULE_1ST_RS2   (SCHEDULE_1ST_RS2),
        .SCHEDULE_1ST_FUNCT3(SCHEDULE_1ST_FUNCT3),
        .SCHEDULE_1ST_FUNCT7(SCHEDULE_1ST_FUNCT7),
        .SCHEDULE_1ST_IMM   (SCHEDULE_1ST_IMM)
    );

    typedef struct {
        bit         rb;
        bit         dv;
        logic [6:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        bit         er;
        bit         wbv;
        logic [4:0] wbrd;
        bit         fl;
        bit         es;
        bit         ev;
        logic [4:0] erd;
    } vec_t;

    vec_t tv[$];
    int   total = 0;
    int   bad = 0;

    function automatic vec_t v(
        input bit rb, input bit dv, input logic [6:0] op,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input bit er, input bit wbv, input logic [4:0] wbrd, input bit fl,
        input bit es, input bit ev, input logic [4:0] erd);
        vec_t r;
        r.rb = rb; r.dv = dv; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.er = er; r.wbv = wbv; r.wbrd = wbrd; r.fl = fl;
        r.es = es; r.ev = ev; r.erd = erd;
        return r;
    endfunction

    function automatic logic [31:0] pc_of(input logic [4:0] rd);
        return 32'h1000 + {25'd0, rd, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(input bit dv, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
        DECODE_2ND_VALID  = dv;
        DECODE_2ND_OPCODE = op;
        DECODE_2ND_RD     = rd;
        DECODE_2ND_RS1    = rs1;
        DECODE_2ND_RS2    = rs2;
        DECODE_2ND_PC     = pc_of(rd);
        DECODE_2ND_IMM    = {27'd0, rd};
        DECODE_2ND_FUNCT3 = 3'd0;
        DECODE_2ND_FUNCT7 = 7'd0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        FLUSH = 1'b0;
        WB_VALID = 1'b0;
        EXEC_READY = 1'b1;
        drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        // 1. reset
        drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("reset stall", STALL, 0);
        chk("reset valid", SCHEDULE_1ST_VALID, 0);
        chk("reset fields", |{SCHEDULE_1ST_PC, SCHEDULE_1ST_OPCODE,
            SCHEDULE_1ST_RD, SCHEDULE_1ST_RS1, SCHEDULE_1ST_RS2,
            SCHEDULE_1ST_FUNCT3, SCHEDULE_1ST_FUNCT7, SCHEDULE_1ST_IMM}, 0);

        // 2. back-to-back independent
        tv.push_back(v(1,1,OP_I_ALU,1,0,0, 1,0,0,0, 0,0,0));
        tv.push_back(v(0,1,OP_I_ALU,2,0,0, 1,0,0,0, 0,0,0));
        tv.push_back(v(0,0,7'd0,0,0,0,     1,0,0,0, 0,1,1));
        tv.push_back(v(0,0,7'd0,0,0,0,     1,1,1,0, 0,1,2));
        tv.push_back(v(0,0,7'd0,0,0,0,     1,1,2,0, 0,0,0));
        // 3. RAW hazard, WB five cycles after issue
        tv.push_back(v(1,1,OP_R,3,1,2, 1,0,0,0, 0,0,0));
        tv.push_back(v(0,1,OP_R,4,3,1, 1,0,0,0, 0,0,0));
        tv.push_back(v(0,0,7'd0,0,0,0, 1,0,0,0, 1,1,3));
        tv.push_back(v(0,0,7'd0,0,0,0, 1,0,0,0, 1,0,0));
        tv.push_back(v(0,0,7'd0,0,0,0, 1,0,0,0, 1,0,0));
        tv.push_back(v(0,0,7'd0,0,0,0, 1,0,0,0, 1,0,0));
        tv.push_back(v(0,0,7'd0,0,0,0, 1,1,3,0, !BYP,0,0));
        tv.push_back(v(0,0,7'd0,0,0,0, 1,0,0,0, 0,BYP,4));
        tv.push_back(v(0,0,7'd0,0,0,0, 1,0,0,0, 0,!BYP,4));
        tv.push_back(v(0,0,7'd0,0,0,0, 1,0,0,0, 0,0,0));
        // 4. backpressure
        tv.push_back(v(1,1,OP_I_ALU,1,0,0, 1,0,0,0, 0,0,0));
        tv.push_back(v(0,1,OP_I_ALU,2,0,0, 1,0,0,0, 0,0,0));
        tv.push_back(v(0,1,OP_I_ALU,3,0,0, 0,0,0,0, 1,1,1));
        tv.push_back(v(0,1,OP_I_ALU,3,0,0, 0,0,0,0, 1,1,1));
        tv.push_back(v(0,1,OP_I_ALU,3,0,0, 0,0,0,0, 1,1,1));
        tv.push_back(v(0,1,OP_I_ALU,3,0,0, 1,0,0,0, 0,1,1));
        tv.push_back(v(0,0,7'd0,0,0,0,     1,0,0,0, 0,1,2));
        tv.push_back(v(0,0,7'd0,0,0,0,     1,0,0,0, 0,1,3));
        tv.push_back(v(0,0,7'd0,0,0,0,     1,0,0,0, 0,0,0));
        // 5. x0 and no-source instrs
        tv.push_back(v(1,1,OP_I_ALU,0,0,0, 1,0,0,0, 0,0,0));
        tv.push_back(v(0,1,OP_LUI,5,0,0,   1,0,0,0, 0,0,0));
        tv.push_back(v(0,1,OP_R,6,0,0,     1,0,0,0, 0,1,0));
        tv.push_back(v(0,0,7'd0,0,0,0,     1,0,0,0, 0,1,5));
        tv.push_back(v(0,0,7'd0,0,0,0,     1,0,0,0, 0,1,6));
        tv.push_back(v(0,0,7'd0,0,0,0,     1,0,0,0, 0,0,0));
        // 6. flush with busy[7] and a held dependent instr
        tv.push_back(v(1,1,OP_I_ALU,7,0,0, 1,0,0,0, 0,0,0));
        tv.push_back(v(0,1,OP_R,8,7,0,     1,0,0,0, 0,0,0));
        tv.push_back(v(0,0,7'd0,0,0,0,     0,0,0,1, 0,1,7));
        tv.push_back(v(0,1,OP_R,8,7,0,     1,0,0,0, 0,0,0));
        tv.push_back(v(0,0,7'd0,0,0,0,     1,0,0,0, 0,0,0));
        tv.push_back(v(0,0,7'd0,0,0,0,     1,0,0,0, 0,1,8));
        tv.push_back(v(0,0,7'd0,0,0,0,     1,0,0,0, 0,0,0));
        // set and clear of the same rd in one cycle: set wins
        tv.push_back(v(1,1,OP_I_ALU,11,0,0, 1,0,0,0,  0,0,0));
        tv.push_back(v(0,1,OP_R,12,11,0,    1,1,11,0, 0,0,0));
        tv.push_back(v(0,0,7'd0,0,0,0,      1,0,0,0,  1,1,11));
        tv.push_back(v(0,0,7'd0,0,0,0,      1,1,11,0, !BYP,0,0));
        tv.push_back(v(0,0,7'd0,0,0,0,      1,0,0,0,  0,BYP,12));
        tv.push_back(v(0,0,7'd0,0,0,0,      1,0,0,0,  0,!BYP,12));
        tv.push_back(v(0,0,7'd0,0,0,0,      1,0,0,0,  0,0,0));

        foreach (tv[i]) begin
            if (tv[i].rb) do_reset();
            drv(tv[i].dv, tv[i].op, tv[i].rd, tv[i].rs1, tv[i].rs2);
            EXEC_READY = tv[i].er;
            WB_VALID   = tv[i].wbv;
            WB_RD      = tv[i].wbrd;
            FLUSH      = tv[i].fl;
            #1;
            chk($sformatf("row%0d stall", i), STALL, tv[i].es);
            chk($sformatf("row%0d valid", i), SCHEDULE_1ST_VALID, tv[i].ev);
            if (tv[i].ev) begin
                chk($sformatf("row%0d rd", i), SCHEDULE_1ST_RD, tv[i].erd);
                chk($sformatf("row%0d pc", i), SCHEDULE_1ST_PC,
                    pc_of(tv[i].erd));
            end
            tick();
        end
        FLUSH = 1'b0;
        WB_VALID = 1'b0;

        // reset mid-operation, then a late WB for the pre-reset instr
        do_reset();
        drv(1'b1, OP_I_ALU, 5'd9, 5'd0, 5'd0);
        tick();
        drv(1'b1, OP_R, 5'd10, 5'd9, 5'd0);
        tick();
        drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        EXEC_READY = 1'b0;
        #1;
        chk("mid stall before rst", STALL, 1);
        chk("mid valid before rst", SCHEDULE_1ST_VALID, 1);
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        EXEC_READY = 1'b1;
        WB_VALID = 1'b1;
        WB_RD = 5'd9;
        #1;
        chk("mid rst stall", STALL, 0);
        chk("mid rst valid", SCHEDULE_1ST_VALID, 0);
        chk("mid rst fields", |{SCHEDULE_1ST_PC, SCHEDULE_1ST_OPCODE,
            SCHEDULE_1ST_RD, SCHEDULE_1ST_RS1, SCHEDULE_1ST_RS2,
            SCHEDULE_1ST_FUNCT3, SCHEDULE_1ST_FUNCT7, SCHEDULE_1ST_IMM}, 0);
        tick();
        WB_VALID = 1'b0;
        drv(1'b1, OP_R, 5'd10, 5'd9, 5'd0);
        #1;
        chk("post rst load stall", STALL, 0);
        tick();
        drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("post rst issue stall", STALL, 0);
        tick();
        chk("post rst valid", SCHEDULE_1ST_VALID, 1);
        chk("post rst rd", SCHEDULE_1ST_RD, 10);
        chk("post rst rs1", SCHEDULE_1ST_RS1, 9);
        chk("post rst opcode", SCHEDULE_1ST_OPCODE, OP_R);
        chk("post rst imm", SCHEDULE_1ST_IMM, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
